// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel timer: per-channel register
// offsets, CTRL/STATUS bit positions and the packed CTRL register layout.
package timer_pkg;

  localparam logic [2:0] REG_COUNT   = 3'd0;
  localparam logic [2:0] REG_PERIOD  = 3'd1;
  localparam logic [2:0] REG_COMPARE = 3'd2;
  localparam logic [2:0] REG_CTRL    = 3'd3;
  localparam logic [2:0] REG_STATUS  = 3'd4;

  localparam int unsigned CTRL_RUN_BIT    = 0;
  localparam int unsigned CTRL_RELOAD_BIT = 1;
  localparam int unsigned CTRL_OVF_IE_BIT = 2;
  localparam int unsigned CTRL_CMP_IE_BIT = 3;
  localparam int unsigned CTRL_PRE_OFFSET = 8;
  localparam int unsigned CTRL_PRE_BITS   = 8;

  localparam int unsigned STAT_RUNNING_BIT = 0;
  localparam int unsigned STAT_OVF_BIT     = 1;
  localparam int unsigned STAT_CMP_BIT     = 2;

  typedef struct packed {
    logic [CTRL_PRE_BITS-1:0] pre;
    logic [3:0]               rsvd;
    logic                     cmp_ie;
    logic                     ovf_ie;
    logic                     reload;
    logic                     run;
  } ctrl_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: COUNT/PERIOD/COMPARE/CTRL registers, 8-bit prescaler,
// down-counter with reload or one-shot stop, and W1C overflow/compare flags.
// Ports:
//   clock, reset_n          clock and asynchronous active-low reset
//   wr_count..wr_status     decoded, chipselect-qualified write strobes
//   write_data              bus write data
//   reg_sel                 register offset for the read mux
//   read_mux                zero-extended 16-bit read value of reg_sel
//   irq_req                 enabled flag request for the combined irq
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned COUNT_W = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        wr_count,
  input  logic        wr_period,
  input  logic        wr_compare,
  input  logic        wr_ctrl,
  input  logic        wr_status,
  input  logic [15:0] write_data,
  input  logic [2:0]  reg_sel,
  output logic [15:0] read_mux,
  output logic        irq_req
);

  logic [COUNT_W-1:0]       count;
  logic [COUNT_W-1:0]       period;
  logic [COUNT_W-1:0]       compare;
  ctrl_t                    ctrl;
  logic [CTRL_PRE_BITS-1:0] pre_cnt;
  logic                     ovf_f;
  logic                     cmp_f;

  logic [COUNT_W-1:0] wd_trunc;
  logic               tick;
  logic               tick_eff;
  logic               ovf_set;
  logic               cmp_set;

  assign wd_trunc = write_data[COUNT_W-1:0];

  // A bus write to COUNT swallows a coincident tick entirely: no decrement,
  // no flag and no one-shot stop come from that tick.
  always_comb begin
    tick     = ctrl.run && (pre_cnt == '0);
    tick_eff = tick && !wr_count;
    ovf_set  = tick_eff && (count == '0);
    cmp_set  = tick_eff && (count == compare);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      period  <= '0;
      compare <= '0;
      ctrl    <= '0;
      pre_cnt <= '0;
      ovf_f   <= 1'b0;
      cmp_f   <= 1'b0;
    end else begin
      if (wr_ctrl)       pre_cnt <= '0;
      else if (tick)     pre_cnt <= ctrl.pre;
      else if (ctrl.run) pre_cnt <= pre_cnt - 8'd1;

      if (wr_count) begin
        count <= wd_trunc;
      end else if (tick) begin
        if (count == '0) begin
          if (ctrl.reload) count <= period;
        end else begin
          count <= count - COUNT_W'(1);
        end
      end

      if (wr_period)  period  <= wd_trunc;
      if (wr_compare) compare <= wd_trunc;

      if (wr_ctrl) begin
        ctrl <= '{pre:    write_data[CTRL_PRE_OFFSET +: CTRL_PRE_BITS],
                  rsvd:   4'h0,
                  cmp_ie: write_data[CTRL_CMP_IE_BIT],
                  ovf_ie: write_data[CTRL_OVF_IE_BIT],
                  reload: write_data[CTRL_RELOAD_BIT],
                  run:    write_data[CTRL_RUN_BIT]};
      end else if (ovf_set && !ctrl.reload) begin
        ctrl.run <= 1'b0;
      end

      ovf_f <= ovf_set || (ovf_f && !(wr_status && write_data[STAT_OVF_BIT]));
      cmp_f <= cmp_set || (cmp_f && !(wr_status && write_data[STAT_CMP_BIT]));
    end
  end

  always_comb begin
    read_mux = '0;
    case (reg_sel)
      REG_COUNT:   read_mux = 16'(count);
      REG_PERIOD:  read_mux = 16'(period);
      REG_COMPARE: read_mux = 16'(compare);
      REG_CTRL:    read_mux = ctrl;
      REG_STATUS:  read_mux = {13'h0, cmp_f, ovf_f, ctrl.run};
      default:     read_mux = '0;
    endcase
  end

  assign irq_req = (ovf_f && ctrl.ovf_ie) || (cmp_f && ctrl.cmp_ie);

endmodule

// File: rtl/timer_multi.sv
// Multi-channel down-counting timer on the Peribus.
// Ports:
//   clock, reset_n     clock and asynchronous active-low reset
//   chipselect         peripheral select, qualifies write_en/read_en
//   addr               {channel, reg[2:0]}
//   write_data         bus write data
//   write_en, read_en  bus strobes
//   read_data          registered read data (1-cycle latency, holds otherwise)
//   irq                OR of all channels' enabled flags
module timer_multi
  import timer_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned COUNT_W = 16,
  parameter int unsigned ADDR_W  = $clog2(NUM_CH) + 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       write_data,
  input  logic              write_en,
  input  logic              read_en,
  output logic [15:0]       read_data,
  output logic              irq
);

  logic [ADDR_W-1:0] ch_sel;
  logic [2:0]        reg_sel;
  logic              bus_wr;
  logic              bus_rd;
  logic [NUM_CH-1:0] ch_hit;
  logic [NUM_CH-1:0] ch_irq;
  logic [15:0]       ch_rd [NUM_CH];
  logic [15:0]       rd_mux;

  assign ch_sel  = addr >> 3;
  assign reg_sel = addr[2:0];
  assign bus_wr  = chipselect && write_en;
  assign bus_rd  = chipselect && read_en;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_hit;

    assign ch_hit[i] = (ch_sel == ADDR_W'(i));
    assign wr_hit    = bus_wr && ch_hit[i];

    timer_channel #(
      .COUNT_W(COUNT_W)
    ) u_channel (
      .clock      (clock),
      .reset_n    (reset_n),
      .wr_count   (wr_hit && (reg_sel == REG_COUNT)),
      .wr_period  (wr_hit && (reg_sel == REG_PERIOD)),
      .wr_compare (wr_hit && (reg_sel == REG_COMPARE)),
      .wr_ctrl    (wr_hit && (reg_sel == REG_CTRL)),
      .wr_status  (wr_hit && (reg_sel == REG_STATUS)),
      .write_data (write_data),
      .reg_sel    (reg_sel),
      .read_mux   (ch_rd[i]),
      .irq_req    (ch_irq[i])
    );
  end

  // Channel indices with no instance never hit, so they read as zero.
  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_hit[i]) rd_mux = ch_rd[i];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    read_data <= '0;
    else if (bus_rd) read_data <= rd_mux;
  end

  assign irq = |ch_irq;

endmodule

// File: tb/tb_timer_multi.sv
module tb_timer_multi;

  localparam int unsigned NCH = 3;
  localparam int unsigned CW  = 8;
  localparam int unsigned AW  = 5;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          chipselect;
  logic [AW-1:0] addr;
  logic [15:0]   write_data;
  logic          write_en;
  logic          read_en;
  logic [15:0]   read_data;
  logic          irq;

  timer_multi #(
    .NUM_CH (NCH),
    .COUNT_W(CW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .addr       (addr),
    .write_data (write_data),
    .write_en   (write_en),
    .read_en    (read_en),
    .read_data  (read_data),
    .irq        (irq)
  );

  always #5 clock = ~clock;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: timer behaviour expressed as "a tick happens every
  // pre+1 cycles counted from the cycle after the last CTRL write".
  int unsigned m_count[NCH], m_period[NCH], m_compare[NCH], m_pre[NCH], m_since[NCH];
  bit          m_run[NCH], m_reload[NCH], m_ovf_ie[NCH], m_cmp_ie[NCH], m_ovf[NCH], m_cmp[NCH];

  typedef struct {
    int unsigned a;
    int unsigned v;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  bit      irq_q[$];

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_count[c] = 0; m_period[c] = 0; m_compare[c] = 0; m_pre[c] = 0; m_since[c] = 0;
      m_run[c] = 0; m_reload[c] = 0; m_ovf_ie[c] = 0; m_cmp_ie[c] = 0; m_ovf[c] = 0; m_cmp[c] = 0;
    end
  endfunction

  function automatic int unsigned model_read(input int unsigned a);
    int unsigned c, r;
    c = a / 8;
    r = a % 8;
    if (c >= NCH) return 0;
    case (r)
      0: return m_count[c];
      1: return m_period[c];
      2: return m_compare[c];
      3: return m_pre[c] * 256 + 8 * m_cmp_ie[c] + 4 * m_ovf_ie[c] + 2 * m_reload[c] + m_run[c];
      4: return 4 * m_cmp[c] + 2 * m_ovf[c] + m_run[c];
      default: return 0;
    endcase
  endfunction

  function automatic bit model_irq();
    bit any;
    any = 0;
    for (int c = 0; c < NCH; c++)
      if ((m_ovf[c] && m_ovf_ie[c]) || (m_cmp[c] && m_cmp_ie[c])) any = 1;
    return any;
  endfunction

  function automatic void model_edge(input bit cs, input bit we, input bit re,
                                     input int unsigned a, input int unsigned wd);
    int unsigned ch, r, mask, cnt;
    bit hit, tick, wcount, ovf_set, cmp_set;
    ch   = a / 8;
    r    = a % 8;
    mask = (1 << CW) - 1;
    if (cs && re) rd_q.push_back('{a, model_read(a)});
    if (reset_n !== 1'b1) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      hit     = cs && we && (ch == c);
      wcount  = hit && (r == 0);
      tick    = m_run[c] && ((m_since[c] % (m_pre[c] + 1)) == 0);
      cnt     = m_count[c];
      ovf_set = 0;
      cmp_set = 0;
      if (tick && !wcount) begin
        cmp_set = (cnt == m_compare[c]);
        if (cnt == 0) begin
          ovf_set = 1;
          if (m_reload[c]) m_count[c] = m_period[c];
          else             m_run[c] = 0;
        end else begin
          m_count[c] = cnt - 1;
        end
      end
      m_since[c]++;
      if (wcount)           m_count[c]   = wd & mask;
      if (hit && r == 1)    m_period[c]  = wd & mask;
      if (hit && r == 2)    m_compare[c] = wd & mask;
      if (hit && r == 3) begin
        m_pre[c]    = (wd >> 8) & 255;
        m_cmp_ie[c] = (wd >> 3) & 1;
        m_ovf_ie[c] = (wd >> 2) & 1;
        m_reload[c] = (wd >> 1) & 1;
        m_run[c]    = wd & 1;
        m_since[c]  = 0;
      end
      m_ovf[c] = ovf_set || (m_ovf[c] && !(hit && r == 4 && ((wd >> 1) & 1) == 1));
      m_cmp[c] = cmp_set || (m_cmp[c] && !(hit && r == 4 && ((wd >> 2) & 1) == 1));
    end
  endfunction

  // One bus cycle: drive at negedge, let the DUT take the edge, advance the
  // model over the same edge and queue the responses it predicts.
  task automatic cycle(input bit cs, input bit we, input bit re,
                       input int unsigned a, input int unsigned wd);
    @(negedge clock);
    chipselect = cs;
    write_en   = we;
    read_en    = re;
    addr       = AW'(a);
    write_data = 16'(wd);
    @(posedge clock);
    model_edge(cs, we, re, a, wd);
    irq_q.push_back(model_irq());
  endtask

  task automatic wr(input int unsigned a, input int unsigned d);
    cycle(1, 1, 0, a, d);
  endtask

  task automatic rd(input int unsigned a);
    cycle(1, 0, 1, a, 0);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  function automatic int unsigned A(input int unsigned c, input int unsigned r);
    return c * 8 + r;
  endfunction

  // Monitor: whatever the model queued for the last edge is checked here.
  initial begin
    rd_exp_t e;
    bit      ei;
    forever begin
      @(negedge clock);
      if (irq_q.size() > 0) begin
        ei = irq_q.pop_front();
        n_cmp++;
        if (irq !== ei) begin
          n_bad++;
          $display("FAIL irq t=%0t got=%b exp=%b", $time, irq, ei);
        end
      end
      if (rd_q.size() > 0) begin
        e = rd_q.pop_front();
        n_cmp++;
        if (read_data !== 16'(e.v)) begin
          n_bad++;
          $display("FAIL read addr=%0d t=%0t got=%04h exp=%04h", e.a, $time, read_data, 16'(e.v));
        end
      end
    end
  end

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL timeout t=%0t", $time);
    finish_run();
  end

  initial begin
    int unsigned a, op, wd;
    bit          was_irq;

    chipselect = 0; write_en = 0; read_en = 0; addr = '0; write_data = '0;
    reset_n = 1'b1;
    model_reset();
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // reset state of every register in every channel
    for (int c = 0; c < NCH; c++)
      for (int r = 0; r < 5; r++) rd(A(c, r));

    // ch0: period 3, reload, ovf_ie, pre=0
    wr(A(0, 1), 3);
    wr(A(0, 0), 3);
    wr(A(0, 3), 16'h0007);
    repeat (6) rd(A(0, 0));
    rd(A(0, 4));
    wr(A(0, 3), 16'h0000);
    wr(A(0, 4), 16'h0002);
    rd(A(0, 4));

    // ch1: one-shot, pre=2
    wr(A(1, 0), 2);
    wr(A(1, 3), 16'h0201);
    repeat (12) rd(A(1, 0));
    rd(A(1, 4));
    rd(A(1, 3));

    // ch2: compare match at 7, one-shot, cmp_ie only
    wr(A(2, 1), 10);
    wr(A(2, 2), 7);
    wr(A(2, 0), 10);
    wr(A(2, 3), 16'h0009);
    repeat (14) rd(A(2, 4));
    wr(A(2, 4), 16'h0004);
    rd(A(2, 4));

    // COUNT write colliding with a tick; W1C colliding with a flag set
    wr(A(0, 1), 5);
    wr(A(0, 3), 16'h0007);
    idle(2);
    wr(A(0, 0), 16'h0055);
    rd(A(0, 0));
    wr(A(0, 0), 1);
    repeat (8) wr(A(0, 4), 16'h0002);
    rd(A(0, 4));

    // width truncation, unmapped registers/channels, deselected writes
    wr(A(1, 0), 16'h1234);
    rd(A(1, 0));
    wr(A(3, 0), 16'hffff);
    wr(A(3, 3), 16'hffff);
    rd(A(3, 0));
    rd(A(3, 3));
    wr(A(1, 5), 16'hffff);
    rd(A(1, 5));
    rd(A(1, 7));
    cycle(0, 1, 0, A(1, 1), 9);
    rd(A(1, 1));

    // asynchronous reset mid-count with irq asserted
    wr(A(0, 3), 16'h0007);
    repeat (8) rd(A(0, 3));
    was_irq = model_irq();
    @(negedge clock);
    #2;
    chipselect = 0; write_en = 0; read_en = 0;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (read_data !== 16'h0000 || irq !== 1'b0 || !was_irq) begin
      n_bad++;
      $display("FAIL async_reset read_data=%04h irq=%b irq_before=%b exp=0000/0/1",
               read_data, irq, was_irq);
    end
    model_reset();
    idle(2);
    @(negedge clock);
    reset_n = 1'b1;
    idle(4);
    for (int c = 0; c < NCH; c++)
      for (int r = 0; r < 5; r++) rd(A(c, r));

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      a  = $urandom_range(0, 31);
      op = $urandom_range(0, 99);
      wd = $urandom_range(0, 65535);
      if (a % 8 == 3) wd = ($urandom_range(0, 3) << 8) | (wd & 15);
      else if (a % 8 < 3 && $urandom_range(0, 1) == 1) wd = $urandom_range(0, 12);
      if (op < 45)      cycle(1, 0, 1, a, wd);
      else if (op < 80) cycle(1, 1, 0, a, wd);
      else if (op < 88) cycle(1, 1, 1, a, wd);
      else if (op < 94) cycle(0, 1, 1, a, wd);
      else              cycle(0, 0, 0, a, wd);
    end
    for (int c = 0; c < NCH; c++)
      for (int r = 0; r < 5; r++) rd(A(c, r));

    idle(2);
    @(negedge clock);
    #1;
    n_cmp++;
    if (rd_q.size() != 0 || irq_q.size() != 0) begin
      n_bad++;
      $display("FAIL queues_drained rd=%0d irq=%0d exp=0/0", rd_q.size(), irq_q.size());
    end
    finish_run();
  end

endmodule
